// File: rtl/hack_pkg.sv
// hack_pkg: shared definitions for the Hack CPU control stage.
//   - data/address widths fixed by the Hack ISA
//   - instruction-register field positions
//   - control FSM state encoding
package hack_pkg;

    localparam int DATA_W  = 16;
    localparam int ADDR_W  = 15;

    // Instruction register field positions
    localparam int IS_C    = 15;   // 0 = A-instruction, 1 = C-instruction
    localparam int A_BIT   = 12;   // ALU y operand: 1 = M (MDR), 0 = A
    localparam int COMP_HI = 11;   // zx nx zy ny f no
    localparam int COMP_LO = 6;
    localparam int DEST_HI = 5;    // A D M
    localparam int DEST_LO = 3;
    localparam int JUMP_HI = 2;    // lt eq gt
    localparam int JUMP_LO = 0;

    // Individual destination bits inside DEST
    localparam int DEST_A  = 5;
    localparam int DEST_D  = 4;
    localparam int DEST_M  = 3;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        MREAD,
        EXEC,
        MWRITE
    } state_t;

endpackage

// File: rtl/hack_jump_unit.sv
// hack_jump_unit: combinational jump-condition evaluation.
//   jump[2:0] : JUMP field of the C-instruction (lt, eq, gt)
//   zr, ng    : ALU result flags (zero, negative)
//   take      : 1 when the jump is taken
module hack_jump_unit (
    input  logic [2:0] jump,
    input  logic       zr,
    input  logic       ng,
    output logic       take
);

    assign take = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);

endmodule

// File: rtl/hack_cpu_ctrl.sv
// hack_cpu_ctrl: multi-cycle control/register stage wrapped around the Hack ALU.
//   clk, reset           : clock, synchronous active-high reset
//   imem_req/addr/ack/data : instruction fetch handshake (addr = PC)
//   dmem_req/we/addr/wdata/ack/rdata : data memory handshake
//   alu_x/alu_y/alu_op   : ALU operands (D, A-or-MDR, IR comp field)
//   alu_out/zr/ng        : combinational ALU results
//   pc, a_reg, d_reg     : architectural state for debug
//   instr_done           : one-cycle pulse when an instruction retires
module hack_cpu_ctrl
    import hack_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [14:0] imem_addr,
    input  logic        imem_ack,
    input  logic [15:0] imem_data,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [14:0] dmem_addr,
    output logic [15:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [15:0] dmem_rdata,
    output logic [15:0] alu_x,
    output logic [15:0] alu_y,
    output logic [5:0]  alu_op,
    input  logic [15:0] alu_out,
    input  logic        alu_zr,
    input  logic        alu_ng,
    output logic [14:0] pc,
    output logic [15:0] a_reg,
    output logic [15:0] d_reg,
    output logic        instr_done
);

    state_t              state, state_nxt;
    logic [DATA_W-1:0]   ir, mdr, wdata;
    logic [ADDR_W-1:0]   waddr;
    logic                take;

    hack_jump_unit u_jump (
        .jump (ir[JUMP_HI:JUMP_LO]),
        .zr   (alu_zr),
        .ng   (alu_ng),
        .take (take)
    );

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= FETCH;
        else       state <= state_nxt;
    end

    // Next state and handshake/retire outputs. Requests are decoded from
    // state, so they drop the cycle after the ack moves the FSM on. They are
    // also masked by reset so nothing is requested while reset is held.
    always_comb begin
        state_nxt  = state;
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        dmem_we    = 1'b0;
        instr_done = 1'b0;
        case (state)
            FETCH: begin
                imem_req = 1'b1;
                if (imem_ack) state_nxt = DECODE;
            end
            DECODE: begin
                if (!ir[IS_C]) begin
                    instr_done = 1'b1;
                    state_nxt  = FETCH;
                end else begin
                    state_nxt  = ir[A_BIT] ? MREAD : EXEC;
                end
            end
            MREAD: begin
                dmem_req = 1'b1;
                if (dmem_ack) state_nxt = EXEC;
            end
            EXEC: begin
                if (ir[DEST_M]) begin
                    state_nxt  = MWRITE;
                end else begin
                    instr_done = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            MWRITE: begin
                dmem_req = 1'b1;
                dmem_we  = 1'b1;
                if (dmem_ack) begin
                    instr_done = 1'b1;
                    state_nxt  = FETCH;
                end
            end
            default: state_nxt = FETCH;
        endcase
        if (reset) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            dmem_we    = 1'b0;
            instr_done = 1'b0;
        end
    end

    // Datapath registers. Non-blocking updates in EXEC mean every
    // destination sees the pre-instruction A/D/PC values.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc    <= '0;
            a_reg <= '0;
            d_reg <= '0;
            ir    <= '0;
            mdr   <= '0;
            wdata <= '0;
            waddr <= '0;
        end else begin
            case (state)
                FETCH:  if (imem_ack) ir <= imem_data;
                DECODE: if (!ir[IS_C]) begin
                    a_reg <= {1'b0, ir[14:0]};
                    pc    <= pc + 15'd1;
                end
                MREAD:  if (dmem_ack) mdr <= dmem_rdata;
                EXEC: begin
                    if (ir[DEST_D]) d_reg <= alu_out;
                    if (ir[DEST_A]) a_reg <= alu_out;
                    if (ir[DEST_M]) begin
                        wdata <= alu_out;
                        waddr <= a_reg[14:0];
                    end
                    pc <= take ? a_reg[14:0] : pc + 15'd1;
                end
                default: ;
            endcase
        end
    end

    assign imem_addr  = pc;
    // The write address is latched so a write stays stable even though
    // EXEC may have just overwritten A.
    assign dmem_addr  = (state == MWRITE) ? waddr : a_reg[14:0];
    assign dmem_wdata = wdata;
    assign alu_x      = d_reg;
    assign alu_y      = ir[A_BIT] ? mdr : a_reg;
    assign alu_op     = ir[COMP_HI:COMP_LO];

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
module tb_hack_cpu_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        imem_req, imem_ack;
    logic [14:0] imem_addr;
    logic [15:0] imem_data;
    logic        dmem_req, dmem_we, dmem_ack;
    logic [14:0] dmem_addr;
    logic [15:0] dmem_wdata, dmem_rdata;
    logic [15:0] alu_x, alu_y, alu_out;
    logic [5:0]  alu_op;
    logic        alu_zr, alu_ng;
    logic [14:0] pc;
    logic [15:0] a_reg, d_reg;
    logic        instr_done;

    always #5 clk = ~clk;

    hack_cpu_ctrl dut (
        .clk(clk), .reset(reset),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_data(imem_data),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op),
        .alu_out(alu_out), .alu_zr(alu_zr), .alu_ng(alu_ng),
        .pc(pc), .a_reg(a_reg), .d_reg(d_reg), .instr_done(instr_done)
    );

    typedef struct {
        logic [14:0] pc;
        logic [15:0] a, d;
        int          lat;   // 0 = latency not checked
        bit          chk;   // check ALU operands seen in EXEC
        logic [5:0]  op;
        logic [15:0] y;
    } exp_t;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } wr_t;

    exp_t        sbq[$];
    wr_t         wq[$];
    logic [15:0] iq[$];
    logic [15:0] dm_mem [0:255];

    int n_cmp = 0, n_bad = 0, done_cnt = 0, cyc = 0;
    int dmem_wait = 0;
    bit ovr_zr = 1'b0, dm_force = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s at cycle %0d", name, cyc);
    endtask

    // Reference Hack ALU
    function automatic logic [15:0] alu_f(logic [15:0] x, logic [15:0] y, logic [5:0] op);
        logic [15:0] xx, yy, o;
        xx = op[5] ? 16'h0 : x;
        if (op[4]) xx = ~xx;
        yy = op[3] ? 16'h0 : y;
        if (op[2]) yy = ~yy;
        o = op[1] ? xx + yy : xx & yy;
        if (op[0]) o = ~o;
        return o;
    endfunction

    always_comb begin
        alu_out = alu_f(alu_x, alu_y, alu_op);
        alu_zr  = ovr_zr | (alu_out == 16'h0);
        alu_ng  = alu_out[15];
    end

    // Memory responders: imem acks as soon as an instruction is queued,
    // dmem acks after dmem_wait wait cycles.
    initial begin
        int dcnt;
        dcnt = 0;
        imem_ack = 1'b0; imem_data = '0; dmem_ack = 1'b0; dmem_rdata = '0;
        forever begin
            @(negedge clk);
            imem_ack = 1'b0;
            if (imem_req && iq.size() > 0) begin
                imem_ack  = 1'b1;
                imem_data = iq.pop_front();
            end
            dmem_ack = 1'b0;
            if (dm_force) begin
                dmem_ack = 1'b1;
            end else if (dmem_req) begin
                if (dcnt >= dmem_wait) begin
                    dmem_ack = 1'b1;
                    dcnt = 0;
                    if (dmem_we) dm_mem[dmem_addr[7:0]] = dmem_wdata;
                    else         dmem_rdata = dm_mem[dmem_addr[7:0]];
                end else begin
                    dcnt++;
                end
            end else begin
                dcnt = 0;
            end
        end
    end

    // Monitor: pops the scoreboards whenever the DUT retires or writes
    initial begin
        exp_t        pe;
        wr_t         w;
        bit          pend, wpend;
        int          fstart;
        logic [5:0]  cop;
        logic [15:0] cy;
        logic [14:0] wa_p;
        logic [15:0] wd_p;
        pend = 0; wpend = 0; fstart = 0; cop = '0; cy = '0; wa_p = '0; wd_p = '0;
        forever begin
            @(negedge clk); #1;
            cyc++;
            if (pend) begin
                chk("pc", 32'(pc), 32'(pe.pc));
                chk("a_reg", 32'(a_reg), 32'(pe.a));
                chk("d_reg", 32'(d_reg), 32'(pe.d));
                done_cnt++;
                pend = 0;
            end
            if (reset) begin
                wpend = 0;
                continue;
            end
            if (wpend) begin
                chk("we_held", {30'd0, dmem_req, dmem_we}, 32'd3);
                chk("waddr_held", 32'(dmem_addr), 32'(wa_p));
                chk("wdata_held", 32'(dmem_wdata), 32'(wd_p));
            end
            wpend = dmem_req && dmem_we && !dmem_ack;
            wa_p  = dmem_addr;
            wd_p  = dmem_wdata;
            if (!imem_req && !dmem_req) begin
                cop = alu_op;
                cy  = alu_y;
            end
            if (imem_req && imem_ack) fstart = cyc;
            if (dmem_req && dmem_we && dmem_ack) begin
                if (wq.size() == 0) fail_evt("unexpected_write");
                else begin
                    w = wq.pop_front();
                    chk("write_addr", 32'(dmem_addr), 32'(w.addr));
                    chk("write_data", 32'(dmem_wdata), 32'(w.data));
                end
            end
            if (instr_done) begin
                if (sbq.size() == 0) fail_evt("unexpected_retire");
                else begin
                    pe = sbq.pop_front();
                    if (pe.lat != 0) chk("latency", 32'(cyc - fstart + 1), 32'(pe.lat));
                    if (pe.chk) begin
                        chk("alu_op", 32'(cop), 32'(pe.op));
                        chk("alu_y", 32'(cy), 32'(pe.y));
                    end
                    pend = 1;
                end
            end
        end
    end

    task automatic push(logic [15:0] ins, logic [14:0] epc, logic [15:0] ea, logic [15:0] ed,
                        int lat, bit ca, logic [5:0] op, logic [15:0] y);
        exp_t e;
        e.pc = epc; e.a = ea; e.d = ed; e.lat = lat; e.chk = ca; e.op = op; e.y = y;
        sbq.push_back(e);
        iq.push_back(ins);
    endtask

    task automatic wait_done(int tgt);
        int k;
        k = 0;
        while (done_cnt < tgt && k < 200) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt < tgt) begin
            fail_evt("retire_timeout");
            sbq.delete(); wq.delete(); iq.delete();
        end
    endtask

    task automatic issue(logic [15:0] ins, logic [14:0] epc, logic [15:0] ea, logic [15:0] ed,
                         int lat, bit ca, logic [5:0] op, logic [15:0] y);
        int tgt;
        tgt = done_cnt + 1;
        push(ins, epc, ea, ed, lat, ca, op, y);
        wait_done(tgt);
    endtask

    initial begin
        int k;
        wr_t w;
        for (int i = 0; i < 256; i++) dm_mem[i] = 16'h0;
        dm_mem[16] = 16'h0007;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_a", 32'(a_reg), 0);
        chk("rst_d", 32'(d_reg), 0);
        chk("rst_reqs", {29'd0, imem_req, dmem_req, dmem_we}, 0);
        chk("rst_done", 32'(instr_done), 0);
        chk("rst_wdata", 32'(dmem_wdata), 0);

        // @5: A-instruction, 2-cycle retire
        @(posedge clk); #2;
        reset = 1'b0;
        push(16'h0005, 15'd1, 16'h0005, 16'h0000, 2, 0, '0, '0);
        @(negedge clk);
        chk("imem_req_rise", 32'(imem_req), 1);
        chk("imem_addr", 32'(imem_addr), 0);
        wait_done(1);

        issue(16'hEC10, 15'd2, 16'h0005, 16'h0005, 3, 1, 6'b110000, 16'h0005);  // D=A
        issue(16'hE301, 15'd5, 16'h0005, 16'h0005, 3, 1, 6'b001100, 16'h0005);  // D;JGT taken
        ovr_zr = 1'b1;
        issue(16'hE301, 15'd6, 16'h0005, 16'h0005, 3, 1, 6'b001100, 16'h0005);  // D;JGT, zr=1
        ovr_zr = 1'b0;
        issue(16'h0010, 15'd7, 16'h0010, 16'h0005, 2, 0, '0, '0);

        // M=M+1 with two wait cycles on both the read and the write
        dmem_wait = 2;
        w.addr = 15'h0010; w.data = 16'h0008; wq.push_back(w);
        issue(16'hFDC8, 15'd8, 16'h0010, 16'h0005, 9, 1, 6'b110111, 16'h0007);
        dmem_wait = 0;

        issue(16'h0030, 15'd9,  16'h0030, 16'h0005, 2, 0, '0, '0);
        issue(16'hEC10, 15'd10, 16'h0030, 16'h0030, 3, 1, 6'b110000, 16'h0030);
        issue(16'h0020, 15'd11, 16'h0020, 16'h0030, 2, 0, '0, '0);
        // AM=D;JMP: write goes to the old A, jump target is the old A
        w.addr = 15'h0020; w.data = 16'h0030; wq.push_back(w);
        issue(16'hE32F, 15'h0020, 16'h0030, 16'h0030, 4, 1, 6'b001100, 16'h0020);

        // PC wrap at 0x7FFF
        issue(16'h7FFF, 15'h0021, 16'h7FFF, 16'h0030, 2, 0, '0, '0);
        issue(16'hEA87, 15'h7FFF, 16'h7FFF, 16'h0030, 3, 1, 6'b101010, 16'h7FFF);  // 0;JMP
        issue(16'h0003, 15'h0000, 16'h0003, 16'h0030, 2, 0, '0, '0);

        // Reset while an M read is outstanding, then a stray ack
        dmem_wait = 50;
        iq.push_back(16'hFDC8);
        k = 0;
        while (!dmem_req && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("mid_dmem_req", 32'(dmem_req), 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #2;
        reset = 1'b1;
        @(posedge clk); #2;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_dmem_req", {30'd0, dmem_req, dmem_we}, 0);
        chk("abort_pc", 32'(pc), 0);
        chk("abort_a", 32'(a_reg), 0);
        chk("abort_d", 32'(d_reg), 0);
        chk("abort_wdata", 32'(dmem_wdata), 0);
        @(posedge clk); #2;
        dm_force = 1'b1;
        @(posedge clk); #2;
        dm_force = 1'b0;
        dmem_wait = 0;
        @(negedge clk);
        chk("stray_dmem_req", 32'(dmem_req), 0);
        chk("stray_pc", 32'(pc), 0);
        chk("stray_a", 32'(a_reg), 0);
        chk("stray_done", 32'(instr_done), 0);
        issue(16'h0009, 15'd1, 16'h0009, 16'h0000, 2, 0, '0, '0);

        repeat (4) @(negedge clk);
        chk("queues_drained", 32'(sbq.size() + wq.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hack_cpu_ctrl.md
# hack_cpu_ctrl

Multi-cycle control and register stage of the Hack CPU, sitting directly around the `alu` block. It fetches 16-bit Hack instructions, holds the A, D and PC registers, and drives the ALU's `x`, `y` and `operation` inputs. It consumes the ALU's `out`, `zr` and `ng` results for register writeback, memory writes and jump decisions. Memory accesses use a req/ack handshake, so instruction and data memories may insert wait states.

## Interface
- No parameters. Widths are fixed by the Hack ISA: 16-bit data and 15-bit addresses.

- `clk` in 1: single clock; all state changes on posedge.
- `reset` in 1: synchronous, active-high.
- `imem_req` out 1: instruction fetch request.
- `imem_addr` out 15: fetch address, equal to PC.
- `imem_ack` in 1: one-cycle acknowledge; `imem_data` is valid in the same cycle.
- `imem_data` in 16: instruction word.
- `dmem_req` out 1: data access request.
- `dmem_we` out 1: 1 = write, 0 = read.
- `dmem_addr` out 15: `A[14:0]`.
- `dmem_wdata` out 16: write data.
- `dmem_ack` in 1: one-cycle acknowledge; `dmem_rdata` is valid in the same cycle.
- `dmem_rdata` in 16: read data.
- `alu_x` out 16: always driven from D.
- `alu_y` out 16: MDR if `IR[12]` is 1, otherwise A.
- `alu_op` out 6: always `IR[11:6]` (zx, nx, zy, ny, f, no).
- `alu_out` in 16, `alu_zr` in 1, `alu_ng` in 1: results from the combinational ALU, valid in the same cycle.
- `pc` out 15, `a_reg` out 16, `d_reg` out 16: architectural state, for debug and verification.
- `instr_done` out 1: one-cycle pulse when an instruction retires.

## Operation
- **States:** FETCH, DECODE, MREAD, EXEC, MWRITE.
- **FETCH:**
  - Hold `imem_req`=1 and `imem_addr`=PC.
  - On `imem_ack`, latch IR from `imem_data` and go to DECODE.
- **DECODE, A-instruction (`IR[15]`=0):**
  - A <= {0, `IR[14:0]`}; PC <= PC+1.
  - Pulse `instr_done`; go to FETCH.
- **DECODE, C-instruction:**
  - If `IR[12]`=1, go to MREAD; otherwise go to EXEC.
- **MREAD:**
  - Hold `dmem_req`=1, `dmem_we`=0, `dmem_addr`=`A[14:0]`.
  - On `dmem_ack`, MDR <= `dmem_rdata`; go to EXEC.
- **EXEC:** sample `alu_out`/`alu_zr`/`alu_ng` once. All of the following use values from before this cycle's updates:
  - `IR[4]` set: D <= `alu_out`.
  - `IR[5]` set: A <= `alu_out`.
  - `IR[3]` set: latch `dmem_wdata` <= `alu_out` and the write address <= old `A[14:0]`.
  - Jump taken = (`IR[2]` & ng) | (`IR[1]` & zr) | (`IR[0]` & !ng & !zr).
  - If taken, PC <= old `A[14:0]`; otherwise PC <= PC+1.
  - If `IR[3]` is set, go to MWRITE. Otherwise pulse `instr_done` and go to FETCH.
- **MWRITE:**
  - Hold `dmem_req`=1, `dmem_we`=1, with latched address and data.
  - On `dmem_ack`, pulse `instr_done` and go to FETCH.
- **Handshake rules:**
  - While a request is high, address, `we` and data are stable until ack.
  - Req drops in the cycle after ack.
  - An ack received while no request is outstanding is ignored.
- **Arithmetic:** PC increments modulo 2^15, so 0x7FFF wraps to 0x0000. Bit 15 of A is never used as an address.

## Timing
- **Reset values** (in the cycle after `reset` is sampled high):
  - State FETCH.
  - PC, A, D, IR, MDR all 0.
  - `imem_req`, `dmem_req`, `dmem_we`, `instr_done` all 0.
  - `dmem_wdata` 0.
- `imem_req` rises in the first cycle after `reset` is low.
- **Latency with zero wait states** (ack in the first request cycle):
  - A-instruction: 2 cycles.
  - C-instruction without M: 3 cycles.
  - C-instruction with an M read: 4 cycles.
  - A write to M adds 1 cycle.
- Each wait cycle adds 1 cycle to the affected state.
- **Reset mid-operation:** the operation aborts immediately. Requests are low in the next cycle, an in-flight ack is discarded, and no partial register update occurs.

## Structure
- **Shared package `hack_pkg`:**
  - State enum.
  - IR field positions: `IS_C`=15, `A_BIT`=12, `COMP`=11:6, `DEST`=5:3, `JUMP`=2:0.
  - Widths: data 16, address 15.
- **Sub-module `hack_jump_unit`:** combinational; inputs JUMP, zr, ng; output `take`.
- The ALU is not instantiated inside this block; the top level wires this block to `alu`.

## Test plan
- **A-instruction:** reset, then `imem` returns 0x0005 with immediate ack. Expect `a_reg`=0x0005, `pc`=1, and `instr_done` 2 cycles after fetch start.
- **D=A:** with A=5, fetch 0xEC10. Expect `alu_op`=110000 and `alu_y`=5; bench returns `alu_out`=5; expect `d_reg`=5 and `pc`=2.
- **D;JGT (0xE301), taken and not taken:** with A=5 and D=5, the ALU returns 5, zr=0, ng=0, so expect `pc`=5. A repeat with zr=1 instead gives `pc`=PC+1.
- **M=M+1 (0xFDC8):** with A=0x0010, `dmem` read ack arrives after 2 wait cycles with 0x0007.
  - Expect `alu_y`=7 and `alu_op`=110111.
  - Bench returns 8; expect a write to addr 0x0010 with data 0x0008.
  - `dmem_we` stays high until ack; `instr_done` follows the write ack.
- **AM=D;JMP (0xE32F):** with A=0x0020 and D=0x0030:
  - Expect M[0x0020] written with 0x0030.
  - Expect `a_reg`=0x0030 and `pc`=0x0020 (old A).
- **Boundaries:**
  - An A-instruction at `pc`=0x7FFF gives `pc`=0x0000.
  - `reset` asserted while `dmem_req` is high drops req the next cycle and zeroes all state; a late `dmem_ack` is ignored.
